dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the byte-addressed data RAM (1-cycle registered read,
//  store decoded from an instruction word). Shares the RAM between the CPU data port (m0) and the
//  debug/loader port (m1). Runs one transaction at a time. Synthesizes the RAM's instruction word
//  from each request's size code and returns load data and a completion pulse.
// PARAMETERS
//  ADDR_W     11  byte-address width of RAM port
//  DATA_W     64  data width
//  FIXED_PRIO 0   0 = round-robin; 1 = m0 always wins when both request
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  mN_req         in   1       (N=0,1) request; fields below held stable while req=1 and gnt=0
//  mN_we          in   1       1 = store, 0 = load
//  mN_funct3      in   3       RISC-V size code (sb/sh/sw/sd 000-011; lb/lh/lw/ld/lbu/lhu/lwu)
//  mN_addr        in   ADDR_W  byte address
//  mN_wdata       in   DATA_W  store data, LSB-aligned
//  mN_gnt         out  1       1-cycle pulse: request accepted
//  mN_rvalid      out  1       1-cycle pulse: transaction complete
//  mN_rdata       out  DATA_W  load result, valid with rvalid (0 for stores/errors)
//  mN_err         out  1       valid with rvalid: illegal funct3, no RAM access made
//  ram_we         out  1       RAM write enable
//  ram_inst       out  32      {17'b0, funct3, 5'b0, opcode}; opcode 0100011 store / 0000011 load
//  ram_address    out  ADDR_W  RAM byte address
//  ram_write_data out  DATA_W  RAM store data
//  ram_read_data  in   DATA_W  RAM registered read result
//  busy           out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - All outputs registered. Reset value of every output = 0. Reset puts FSM in IDLE and sets the
//    RR pointer to m0. Async reset mid-transaction: the transaction is dropped, ram_we drops at once,
//    and no gnt/rvalid is issued for it.
//  - FSM: IDLE -> ISSUE -> RESP -> IDLE. No back-to-back overlap.
//  - req is sampled only in IDLE.
//  - Cycle T (IDLE, any req): pick winner, latch its fields, gnt=1 in T+1, go to ISSUE.
//    Both requesting, round-robin: the port not served last wins. After each grant, the pointer
//    moves to the other port.
//  - T+1 (ISSUE): drive ram_address/ram_write_data/ram_inst from latched fields. ram_we=1 only for a
//    legal store. The RAM performs the store or registers the read at the end of T+1.
//  - T+2 (RESP): ram_we=0. At the end of T+2, capture ram_read_data into rdata (loads) and set
//    rvalid=1 for T+3. Then go to IDLE.
//  - Latency: req@T -> gnt@T+1 -> rvalid@T+3. Throughput: 1 transaction per 3 cycles.
//  - Requester drops req in the gnt cycle unless it issues a new request. req still high in IDLE
//    is a new request.
//  - Illegal funct3: store with funct3[2]=1, or load with 111. Granted normally, no RAM write,
//    ram_inst=0, rvalid with err=1 and rdata=0 at the same latency.
//  - Outside ISSUE: ram_inst=0, ram_we=0, address/data=0.
//  - rdata and err hold their value until the next rvalid on that port.
//  - Simultaneous rvalid on one port and new req on the other: the new req is accepted in that same
//    IDLE cycle.
//  - No alignment or range check: the address passes through unmodified.
// TESTING
//  1 m0 sd addr=0x010 wdata=0x1122334455667788, then m0 ld 0x010 -> gnt@+1, rvalid@+3,
//    rdata=0x1122334455667788, err=0.
//  2 m1 sb 0x020=0x80, then m1 lb 0x020 -> rdata=0xFFFFFFFFFFFFFF80; m1 lbu -> 0x80.
//  3 m0, m1 req same cycle after reset, RR -> m0 granted first, m1 granted at the next IDLE;
//    repeat -> order alternates. FIXED_PRIO=1 -> m0 always first.
//  4 m0 store funct3=100 -> rvalid, err=1, ram_we never 1, prior RAM contents unchanged on readback.
//  5 rst asserted during ISSUE of m1 sw -> ram_we=0 immediately, no rvalid, busy=0;
//    after release, m0 request served normally.
//  6 m0 holds req across rvalid -> second transaction granted in that IDLE cycle (gnt 3 cycles apart).

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the data RAM: one transaction at a time,
// RAM instruction word synthesized from the request size code, load data returned with rvalid.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 64,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [2:0]        m0_funct3,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [2:0]        m1_funct3,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              ram_we,
  output logic [31:0]       ram_inst,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic              busy
);

  // state  | meaning
  // IDLE   | waiting for a request; arbitration happens here
  // ISSUE  | RAM port driven with the granted request
  // RESP   | RAM read result available; completion issued next cycle
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  state_t state_q, state_d;

  logic rr_q;   // 1: m1 has priority on the next contended cycle
  logic sel_q;
  logic we_q;
  logic ill_q;

  logic              any_req;
  logic              pick_m1;
  logic              sel_we;
  logic [2:0]        sel_f3;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_ill;

  logic              m0_gnt_d, m1_gnt_d;
  logic              m0_rvalid_d, m1_rvalid_d;
  logic [DATA_W-1:0] m0_rdata_d, m1_rdata_d;
  logic              m0_err_d, m1_err_d;
  logic              ram_we_d;
  logic [31:0]       ram_inst_d;
  logic [ADDR_W-1:0] ram_address_d;
  logic [DATA_W-1:0] ram_write_data_d;
  logic [DATA_W-1:0] resp_data;

  always_comb begin
    any_req = m0_req | m1_req;
    pick_m1 = m1_req & (~m0_req | ((FIXED_PRIO == 1'b0) & rr_q));
    if (pick_m1) begin
      sel_we    = m1_we;
      sel_f3    = m1_funct3;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end else begin
      sel_we    = m0_we;
      sel_f3    = m0_funct3;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
    end
    // stores only exist up to sd; loads have no 111 encoding
    sel_ill = sel_we ? sel_f3[2] : (sel_f3 == 3'b111);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q  <= 1'b0;
      sel_q <= 1'b0;
      we_q  <= 1'b0;
      ill_q <= 1'b0;
    end else if (state_q == S_IDLE && any_req) begin
      rr_q  <= ~pick_m1;
      sel_q <= pick_m1;
      we_q  <= sel_we;
      ill_q <= sel_ill;
    end
  end

  // Stores and rejected requests return zero data.
  assign resp_data = (we_q | ill_q) ? '0 : ram_read_data;

  always_comb begin
    m0_gnt_d         = 1'b0;
    m1_gnt_d         = 1'b0;
    m0_rvalid_d      = 1'b0;
    m1_rvalid_d      = 1'b0;
    m0_rdata_d       = m0_rdata;
    m1_rdata_d       = m1_rdata;
    m0_err_d         = m0_err;
    m1_err_d         = m1_err;
    ram_we_d         = 1'b0;
    ram_inst_d       = '0;
    ram_address_d    = '0;
    ram_write_data_d = '0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          m0_gnt_d         = ~pick_m1;
          m1_gnt_d         = pick_m1;
          ram_we_d         = sel_we & ~sel_ill;
          ram_inst_d       = sel_ill ? 32'd0 :
                             {17'd0, sel_f3, 5'd0, (sel_we ? OP_STORE : OP_LOAD)};
          ram_address_d    = sel_addr;
          ram_write_data_d = sel_wdata;
        end
      end
      S_RESP: begin
        if (sel_q) begin
          m1_rvalid_d = 1'b1;
          m1_rdata_d  = resp_data;
          m1_err_d    = ill_q;
        end else begin
          m0_rvalid_d = 1'b1;
          m0_rdata_d  = resp_data;
          m0_err_d    = ill_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_gnt         <= 1'b0;
      m1_gnt         <= 1'b0;
      m0_rvalid      <= 1'b0;
      m1_rvalid      <= 1'b0;
      m0_rdata       <= '0;
      m1_rdata       <= '0;
      m0_err         <= 1'b0;
      m1_err         <= 1'b0;
      ram_we         <= 1'b0;
      ram_inst       <= '0;
      ram_address    <= '0;
      ram_write_data <= '0;
      busy           <= 1'b0;
    end else begin
      m0_gnt         <= m0_gnt_d;
      m1_gnt         <= m1_gnt_d;
      m0_rvalid      <= m0_rvalid_d;
      m1_rvalid      <= m1_rvalid_d;
      m0_rdata       <= m0_rdata_d;
      m1_rdata       <= m1_rdata_d;
      m0_err         <= m0_err_d;
      m1_err         <= m1_err_d;
      ram_we         <= ram_we_d;
      ram_inst       <= ram_inst_d;
      ram_address    <= ram_address_d;
      ram_write_data <= ram_write_data_d;
      busy           <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural RAM model, per-port expectation queues,
// and a second fixed-priority instance sharing the same request inputs.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [2:0]  m0_funct3, m1_funct3;
  logic [10:0] m0_addr, m1_addr;
  logic [63:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [63:0] m0_rdata, m1_rdata;
  logic        ram_we, busy;
  logic [31:0] ram_inst;
  logic [10:0] ram_address;
  logic [63:0] ram_write_data, ram_read_data;

  logic        f_m0_gnt, f_m0_rvalid, f_m0_err, f_m1_gnt, f_m1_rvalid, f_m1_err;
  logic [63:0] f_m0_rdata, f_m1_rdata;
  logic        f_ram_we, f_busy;
  logic [31:0] f_ram_inst;
  logic [10:0] f_ram_address;
  logic [63:0] f_ram_write_data;
  logic [63:0] f_ram_read_data = 64'd0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_funct3(m0_funct3), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_funct3(m1_funct3), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_we(ram_we), .ram_inst(ram_inst), .ram_address(ram_address),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data), .busy(busy)
  );

  dmem_arbiter #(.FIXED_PRIO(1'b1)) dut_fix (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_funct3(m0_funct3), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_funct3(m1_funct3), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
    .ram_we(f_ram_we), .ram_inst(f_ram_inst), .ram_address(f_ram_address),
    .ram_write_data(f_ram_write_data), .ram_read_data(f_ram_read_data), .busy(f_busy)
  );

  // RAM model: decodes the instruction word, 1-cycle registered read
  logic [7:0] mem [0:2047];
  initial for (int i = 0; i < 2048; i++) mem[i] = 8'h00;

  function automatic logic [63:0] load_val(input logic [2:0] f3, input logic [10:0] a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = mem[a + 11'(i)];
    case (f3)
      3'b000:  return {{56{v[7]}}, v[7:0]};
      3'b001:  return {{48{v[15]}}, v[15:0]};
      3'b010:  return {{32{v[31]}}, v[31:0]};
      3'b011:  return v;
      3'b100:  return {56'd0, v[7:0]};
      3'b101:  return {48'd0, v[15:0]};
      3'b110:  return {32'd0, v[31:0]};
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_we && ram_inst[6:0] == 7'b0100011)
      for (int i = 0; i < 8; i++)
        if (i < (1 << ram_inst[13:12])) mem[ram_address + 11'(i)] <= ram_write_data[8*i +: 8];
    if (ram_inst[6:0] == 7'b0000011) ram_read_data <= load_val(ram_inst[14:12], ram_address);
  end

  typedef struct { logic [63:0] rd; logic er; } exp_t;
  typedef struct {
    int glat; int rlat; logic [63:0] rd; logic er; logic we_seen;
    logic [31:0] inst_g; logic [10:0] addr_g; logic [63:0] wdat_g;
  } obs_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic drive(input bit p, input logic rq, input logic we, input logic [2:0] f3,
                       input logic [10:0] a, input logic [63:0] wd);
    if (!p) begin m0_req = rq; m0_we = we; m0_funct3 = f3; m0_addr = a; m0_wdata = wd; end
    else    begin m1_req = rq; m1_we = we; m1_funct3 = f3; m1_addr = a; m1_wdata = wd; end
  endtask

  // Drives one request, drops it on grant, records latencies (in cycles) and outputs.
  task automatic txn(input bit p, input logic we, input logic [2:0] f3, input logic [10:0] a,
                     input logic [63:0] wd, output obs_t o);
    o.glat = -1; o.rlat = -1; o.rd = '0; o.er = 1'b0; o.we_seen = 1'b0;
    o.inst_g = '0; o.addr_g = '0; o.wdat_g = '0;
    @(negedge clk);
    drive(p, 1'b1, we, f3, a, wd);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ram_we) o.we_seen = 1'b1;
      if ((p ? m1_gnt : m0_gnt) && o.glat < 0) begin
        o.glat = i; o.inst_g = ram_inst; o.addr_g = ram_address; o.wdat_g = ram_write_data;
        drive(p, 1'b0, 1'b0, 3'b000, 11'd0, 64'd0);
      end
      if (p ? m1_rvalid : m0_rvalid) begin
        o.rlat = i; o.rd = p ? m1_rdata : m0_rdata; o.er = p ? m1_err : m0_err;
        break;
      end
    end
    drive(p, 1'b0, 1'b0, 3'b000, 11'd0, 64'd0);
  endtask

  task automatic test_reset;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, ram_we, busy} !== 8'd0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00000000",
        {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, ram_we, busy});
    end
    n_cmp++;
    if ({m0_rdata, m1_rdata, ram_inst, ram_address, ram_write_data} !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0",
        {m0_rdata, m1_rdata, ram_inst, ram_address, ram_write_data});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_store_load;
    obs_t o; exp_t e;
    sb0.push_back('{64'd0, 1'b0});
    txn(0, 1'b1, 3'b011, 11'h010, 64'h1122334455667788, o);
    e = sb0.pop_front();
    n_cmp++;
    if (o.glat !== 1 || o.rlat !== 3) begin
      n_bad++; $display("FAIL sd_latency: got gnt %0d rvalid %0d want 1 3", o.glat, o.rlat);
    end
    n_cmp++;
    if (o.inst_g !== 32'h0000_3023 || o.addr_g !== 11'h010 || o.wdat_g !== 64'h1122334455667788) begin
      n_bad++; $display("FAIL sd_ram_port: got inst %h addr %h data %h want 00003023 010 1122334455667788",
        o.inst_g, o.addr_g, o.wdat_g);
    end
    n_cmp++;
    if (o.rd !== e.rd || o.er !== e.er) begin
      n_bad++; $display("FAIL sd_resp: got %h/%b want %h/%b", o.rd, o.er, e.rd, e.er);
    end
    sb0.push_back('{64'h1122334455667788, 1'b0});
    txn(0, 1'b0, 3'b011, 11'h010, 64'd0, o);
    e = sb0.pop_front();
    n_cmp++;
    if (o.glat !== 1 || o.rlat !== 3) begin
      n_bad++; $display("FAIL ld_latency: got gnt %0d rvalid %0d want 1 3", o.glat, o.rlat);
    end
    n_cmp++;
    if (o.inst_g !== 32'h0000_3003 || o.we_seen !== 1'b0) begin
      n_bad++; $display("FAIL ld_ram_port: got inst %h we %b want 00003003 0", o.inst_g, o.we_seen);
    end
    n_cmp++;
    if (o.rd !== e.rd || o.er !== e.er) begin
      n_bad++; $display("FAIL ld_resp: got %h/%b want %h/%b", o.rd, o.er, e.rd, e.er);
    end
  endtask

  task automatic test_byte_sign;
    obs_t o; exp_t e;
    logic [2:0]  f3s [4] = '{3'b000, 3'b000, 3'b100, 3'b001};
    logic        wes [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [63:0] exps[4] = '{64'd0, 64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'h0080};
    mem[11'h021] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      sb1.push_back('{exps[k], 1'b0});
      txn(1, wes[k], f3s[k], 11'h020, 64'hDEAD_BEEF_CAFE_1280, o);
      e = sb1.pop_front();
      n_cmp++;
      if (o.rlat !== 3 || o.rd !== e.rd || o.er !== e.er) begin
        n_bad++; $display("FAIL m1_byte_%0d: got lat %0d %h/%b want lat 3 %h/%b",
          k, o.rlat, o.rd, o.er, e.rd, e.er);
      end
    end
  endtask

  task automatic test_arbitration;
    obs_t o; exp_t e;
    int g0, g1, r0, r1, gf0, gf1;
    logic [63:0] d0, d1;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int round = 0; round < 2; round++) begin
      if (round == 1) begin
        sb0.push_back('{64'h1122334455667788, 1'b0});
        txn(0, 1'b0, 3'b011, 11'h010, 64'd0, o);
        e = sb0.pop_front();
        n_cmp++;
        if (o.rd !== e.rd) begin n_bad++; $display("FAIL rr_solo: got %h want %h", o.rd, e.rd); end
      end
      sb0.push_back('{64'h1122334455667788, 1'b0});
      sb1.push_back('{64'h80, 1'b0});
      g0 = -1; g1 = -1; r0 = -1; r1 = -1; gf0 = -1; gf1 = -1; d0 = '0; d1 = '0;
      @(negedge clk);
      drive(0, 1'b1, 1'b0, 3'b011, 11'h010, 64'd0);
      drive(1, 1'b1, 1'b0, 3'b100, 11'h020, 64'd0);
      for (int i = 1; i <= 14; i++) begin
        @(negedge clk);
        if (f_m0_gnt && gf0 < 0) gf0 = i;
        if (f_m1_gnt && gf1 < 0) gf1 = i;
        if (m0_gnt && g0 < 0) begin g0 = i; drive(0, 0, 0, 0, 0, 0); end
        if (m1_gnt && g1 < 0) begin g1 = i; drive(1, 0, 0, 0, 0, 0); end
        if (m0_rvalid) begin r0 = i; d0 = m0_rdata; end
        if (m1_rvalid) begin r1 = i; d1 = m1_rdata; end
      end
      n_cmp++;
      if (g0 !== (round == 0 ? 4'd1 : 4'd4) || g1 !== (round == 0 ? 4'd4 : 4'd1)) begin
        n_bad++; $display("FAIL rr_order_%0d: got m0 %0d m1 %0d", round, g0, g1);
      end
      n_cmp++;
      if (r0 !== g0 + 2 || r1 !== g1 + 2) begin
        n_bad++; $display("FAIL rr_rvalid_%0d: got m0 %0d m1 %0d want %0d %0d", round, r0, r1, g0 + 2, g1 + 2);
      end
      n_cmp++;
      if (gf0 !== 1 || gf1 == 1) begin
        n_bad++; $display("FAIL fixed_prio_%0d: got m0 %0d m1 %0d want m0 1", round, gf0, gf1);
      end
      e = sb0.pop_front();
      n_cmp++;
      if (d0 !== e.rd) begin n_bad++; $display("FAIL rr_m0_data_%0d: got %h want %h", round, d0, e.rd); end
      e = sb1.pop_front();
      n_cmp++;
      if (d1 !== e.rd) begin n_bad++; $display("FAIL rr_m1_data_%0d: got %h want %h", round, d1, e.rd); end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_illegal;
    obs_t o; exp_t e;
    sb0.push_back('{64'd0, 1'b0});
    txn(0, 1'b1, 3'b011, 11'h080, 64'h0123456789ABCDEF, o);
    e = sb0.pop_front();
    sb0.push_back('{64'd0, 1'b1});
    txn(0, 1'b1, 3'b100, 11'h080, 64'hFFFF_FFFF_FFFF_FFFF, o);
    e = sb0.pop_front();
    n_cmp++;
    if (o.glat !== 1 || o.rlat !== 3 || o.rd !== e.rd || o.er !== e.er) begin
      n_bad++; $display("FAIL ill_store: got lat %0d/%0d %h/%b want 1/3 %h/%b",
        o.glat, o.rlat, o.rd, o.er, e.rd, e.er);
    end
    n_cmp++;
    if (o.we_seen !== 1'b0 || o.inst_g !== 32'd0) begin
      n_bad++; $display("FAIL ill_store_ram: got we %b inst %h want 0 0", o.we_seen, o.inst_g);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (m0_err !== 1'b1) begin n_bad++; $display("FAIL err_hold: got %b want 1", m0_err); end
    sb0.push_back('{64'h0123456789ABCDEF, 1'b0});
    txn(0, 1'b0, 3'b011, 11'h080, 64'd0, o);
    e = sb0.pop_front();
    n_cmp++;
    if (o.rd !== e.rd || o.er !== e.er) begin
      n_bad++; $display("FAIL ill_readback: got %h/%b want %h/%b", o.rd, o.er, e.rd, e.er);
    end
    sb1.push_back('{64'd0, 1'b1});
    txn(1, 1'b0, 3'b111, 11'h080, 64'd0, o);
    e = sb1.pop_front();
    n_cmp++;
    if (o.rlat !== 3 || o.rd !== e.rd || o.er !== e.er || o.inst_g !== 32'd0) begin
      n_bad++; $display("FAIL ill_load: got lat %0d %h/%b inst %h want 3 %h/%b 0",
        o.rlat, o.rd, o.er, o.inst_g, e.rd, e.er);
    end
  endtask

  task automatic test_reset_abort;
    obs_t o; exp_t e;
    int rv_seen;
    sb0.push_back('{64'd0, 1'b0});
    txn(0, 1'b1, 3'b010, 11'h040, 64'h0000_0000_A5A5_A5A5, o);
    e = sb0.pop_front();
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 3'b010, 11'h040, 64'h0000_0000_1234_5678);
    @(negedge clk);
    n_cmp++;
    if (m1_gnt !== 1'b1 || ram_we !== 1'b1) begin
      n_bad++; $display("FAIL abort_issue: got gnt %b we %b want 1 1", m1_gnt, ram_we);
    end
    drive(1, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (ram_we !== 1'b0 || busy !== 1'b0 || m1_gnt !== 1'b0) begin
      n_bad++; $display("FAIL abort_async: got we %b busy %b gnt %b want 0 0 0", ram_we, busy, m1_gnt);
    end
    rv_seen = 0;
    repeat (2) begin @(negedge clk); if (m1_rvalid) rv_seen++; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk); if (m1_rvalid) rv_seen++; end
    n_cmp++;
    if (rv_seen !== 0) begin n_bad++; $display("FAIL abort_rvalid: got %0d want 0", rv_seen); end
    sb0.push_back('{64'hFFFF_FFFF_A5A5_A5A5, 1'b0});
    txn(0, 1'b0, 3'b010, 11'h040, 64'd0, o);
    e = sb0.pop_front();
    n_cmp++;
    if (o.glat !== 1 || o.rlat !== 3 || o.rd !== e.rd || o.er !== e.er) begin
      n_bad++; $display("FAIL abort_after: got lat %0d/%0d %h/%b want 1/3 %h/%b",
        o.glat, o.rlat, o.rd, o.er, e.rd, e.er);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int g[2];
    int r[2];
    logic [63:0] d[2];
    int ng, nr;
    ng = 0; nr = 0;
    g[0] = -1; g[1] = -1; r[0] = -1; r[1] = -1; d[0] = '0; d[1] = '0;
    sb0.push_back('{64'h1122334455667788, 1'b0});
    sb0.push_back('{64'hFFFF_FFFF_A5A5_A5A5, 1'b0});
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 3'b011, 11'h010, 64'd0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (m0_gnt && ng < 2) begin
        g[ng] = i;
        if (ng == 0) drive(0, 1'b1, 1'b0, 3'b010, 11'h040, 64'd0);
        else         drive(0, 0, 0, 0, 0, 0);
        ng++;
      end
      if (m0_rvalid && nr < 2) begin r[nr] = i; d[nr] = m0_rdata; nr++; end
    end
    drive(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if (g[0] !== 1 || g[1] !== 4) begin
      n_bad++; $display("FAIL b2b_gnt: got %0d %0d want 1 4", g[0], g[1]);
    end
    n_cmp++;
    if (r[0] !== 3 || r[1] !== 6) begin
      n_bad++; $display("FAIL b2b_rvalid: got %0d %0d want 3 6", r[0], r[1]);
    end
    for (int k = 0; k < 2; k++) begin
      e = sb0.pop_front();
      n_cmp++;
      if (d[k] !== e.rd) begin n_bad++; $display("FAIL b2b_data_%0d: got %h want %h", k, d[k], e.rd); end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    test_reset();
    test_store_load();
    test_byte_sign();
    test_arbitration();
    test_illegal();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
